// File: rtl/ccff_bitstream_loader.sv
// Serializes DATA_W bitstream words MSB-first onto the configuration flip-flop chain with a gated shift enable.
// Readback of ccff_tail is built only when CCFF_LOADER_READBACK_EN is defined.
module ccff_bitstream_loader #(
    parameter int  DATA_W    = 8,
    parameter int  CHAIN_LEN = 1024,
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din_data,
    output logic              din_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_shl;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  bit_count_q;
    logic              head_q;
    logic              shift_en_q;
    logic              busy_q;
    logic              done_q;
    logic              last_bit;
    logic              word_end;
    logic              accept;

    assign last_bit  = (bit_count_q == CNT_LAST);
    assign word_end  = (idx_q == IDX_LAST);
    assign sr_shl    = sr_q << 1;
    // A new word may be taken on the final bit of the current one so shifting continues without a bubble.
    assign din_ready = (state_q == S_LOAD) || ((state_q == S_SHIFT) && word_end && !last_bit);
    assign accept    = din_valid && din_ready;

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            bit_count_q <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bit_count_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        sr_q       <= din_data;
                        idx_q      <= '0;
                        head_q     <= din_data[DATA_W-1];
                        shift_en_q <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bit_count_q <= bit_count_q + CNT_W'(1);
                    if (last_bit) begin
                        shift_en_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (accept) begin
                        sr_q   <= din_data;
                        idx_q  <= '0;
                        head_q <= din_data[DATA_W-1];
                    end else if (word_end) begin
                        shift_en_q <= 1'b0;
                        state_q    <= S_LOAD;
                    end else begin
                        sr_q   <= sr_shl;
                        idx_q  <= idx_q + IDX_W'(1);
                        head_q <= sr_shl[DATA_W-1];
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_count     = bit_count_q;

`ifdef CCFF_LOADER_READBACK_EN
    logic [DATA_W-1:0] rb_acc_q;
    logic [DATA_W-1:0] rb_acc_d;
    logic [DATA_W-1:0] rb_data_q;
    logic              rb_valid_q;

    // Tail bits are placed by in-word index, so a truncated final word comes out left-justified.
    always_comb begin
        rb_acc_d                   = rb_acc_q;
        rb_acc_d[IDX_LAST - idx_q] = ccff_tail;
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            rb_acc_q   <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (state_q == S_SHIFT) begin
                if (word_end || last_bit) begin
                    rb_data_q  <= rb_acc_d;
                    rb_valid_q <= 1'b1;
                    rb_acc_q   <= '0;
                end else begin
                    rb_acc_q <= rb_acc_d;
                end
            end
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_data     = '0;
    assign rb_valid    = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: 16- and 12-flop chains behind one shared stimulus port, checked against a bit-level chain model.
module tb_ccff_bitstream_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din_data = 8'h00;
    int         sel = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;

    logic       start0, start1, v0, v1, tail;
    logic       rdy0, head0, en0, busy0, done0, rbv0;
    logic       rdy1, head1, en1, busy1, done1, rbv1;
    logic [4:0] cnt0;
    logic [3:0] cnt1;
    logic [7:0] rb0, rb1;
    logic       o_rdy, o_head, o_en, o_busy, o_done, o_rb_valid;
    logic [4:0] o_cnt;
    logic [7:0] o_rb_data;
    logic [15:0] chain = 16'h0000;

    assign start0     = start && (sel == 0);
    assign start1     = start && (sel != 0);
    assign v0         = din_valid && (sel == 0);
    assign v1         = din_valid && (sel != 0);
    assign o_rdy      = (sel != 0) ? rdy1 : rdy0;
    assign o_head     = (sel != 0) ? head1 : head0;
    assign o_en       = (sel != 0) ? en1 : en0;
    assign o_busy     = (sel != 0) ? busy1 : busy0;
    assign o_done     = (sel != 0) ? done1 : done0;
    assign o_cnt      = (sel != 0) ? {1'b0, cnt1} : cnt0;
    assign o_rb_data  = (sel != 0) ? rb1 : rb0;
    assign o_rb_valid = (sel != 0) ? rbv1 : rbv0;
    assign tail       = (sel != 0) ? chain[11] : chain[15];

    // Chain model: bit 0 nearest the head, the active length's top bit is the tail.
    always @(posedge clk) if (o_en) chain <= {chain[14:0], o_head};

    ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(16)) u_dut16 (
        .prog_clk(clk), .prog_reset(rst), .start(start0), .din_valid(v0), .din_data(din_data),
        .din_ready(rdy0), .ccff_head(head0), .ccff_shift_en(en0), .ccff_tail(tail), .busy(busy0),
        .done(done0), .bit_count(cnt0), .rb_data(rb0), .rb_valid(rbv0));

    ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(12)) u_dut12 (
        .prog_clk(clk), .prog_reset(rst), .start(start1), .din_valid(v1), .din_data(din_data),
        .din_ready(rdy1), .ccff_head(head1), .ccff_shift_en(en1), .ccff_tail(tail), .busy(busy1),
        .done(done1), .bit_count(cnt1), .rb_data(rb1), .rb_valid(rbv1));

    int         len, nw, gap_max;
    logic [7:0] wq[4];
    int         gap[4];
    logic       exp_bit[16];
    logic       got_bit[16];
    logic [7:0] exp_rb[2];
    logic [7:0] got_rb[4];

    task automatic run_session(input int start_at);
        int nshift, wi, withheld, ndone, nrb, extra_rdy, gap_run, nexp_rb, bad;
        logic acc, acc_prev, prev_en, last_head, done_prev, finished, rb_bad;
        logic [15:0] pre_chain;
        len = (sel != 0) ? 12 : 16;
        pre_chain = chain;
        for (int i = 0; i < len; i++) exp_bit[i] = wq[i / 8][7 - (i % 8)];
        nexp_rb = (len + 7) / 8;
        for (int k = 0; k < nexp_rb; k++) begin
            exp_rb[k] = 8'h00;
            for (int b = 0; b < 8; b++)
                if (8 * k + b < len) exp_rb[k][7 - b] = pre_chain[len - 1 - (8 * k + b)];
        end
        @(negedge clk);
        start = 1'b1; din_valid = 1'($urandom_range(0, 1)); din_data = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({o_busy, o_rdy} !== 2'b11) begin
            tests_failed++; $display("FAIL start_to_load: busy,ready=%b expected 11", {o_busy, o_rdy});
        end
        nshift = 0; wi = 0; withheld = 0; ndone = 0; nrb = 0; extra_rdy = 0; gap_run = 0; gap_max = 0;
        acc_prev = 0; prev_en = 0; last_head = o_head; done_prev = 0; finished = 0; rb_bad = 0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (done_prev) begin
                finished = 1;
                tests_run++;
                if ({o_busy, o_rdy} !== 2'b00) begin
                    tests_failed++; $display("FAIL idle_after_done: busy,ready=%b expected 00", {o_busy, o_rdy});
                end
            end
            if (o_busy) begin
                tests_run++;
                if (o_cnt !== 5'(nshift)) begin
                    tests_failed++; $display("FAIL bit_count: got %0d expected %0d", o_cnt, nshift);
                end
            end
            if (acc_prev) begin
                tests_run++;
                if (o_en !== 1'b1) begin
                    tests_failed++; $display("FAIL first_bit_latency: shift_en=%b expected 1", o_en);
                end
            end
            if (o_en) begin
                if (nshift < 16) got_bit[nshift] = o_head;
                nshift++; last_head = o_head; gap_run = 0;
            end else if (o_busy && nshift > 0 && nshift < len) begin
                gap_run++;
                if (gap_run > gap_max) gap_max = gap_run;
                tests_run++;
                if (o_head !== last_head) begin
                    tests_failed++; $display("FAIL head_hold: got %b expected %b", o_head, last_head);
                end
            end
            if (o_done) begin
                ndone++;
                tests_run++;
                if (!(prev_en && nshift == len)) begin
                    tests_failed++; $display("FAIL done_timing: prev_en=%b shifts=%0d expected 1/%0d", prev_en, nshift, len);
                end
            end
            done_prev = o_done;
            if (o_rb_valid) begin
                if (nrb < 4) got_rb[nrb] = o_rb_data;
                nrb++;
`ifdef CCFF_LOADER_READBACK_EN
                if (nrb == nexp_rb) begin
                    tests_run++;
                    if (o_done !== 1'b1) begin
                        tests_failed++; $display("FAIL rb_last_with_done: done=%b expected 1", o_done);
                    end
                end
`endif
            end
            if (o_rb_valid !== 1'b0 || o_rb_data !== 8'h00) rb_bad = 1;
            start = (start_at >= 0 && o_en && nshift == start_at) ? 1'b1 : 1'b0;
            acc = 0;
            if (o_rdy) begin
                if (wi < nw && withheld >= gap[wi]) begin
                    din_valid = 1'b1; din_data = wq[wi]; acc = 1; wi++; withheld = 0;
                end else begin
                    din_valid = 1'b0; din_data = 8'($urandom);
                    if (wi < nw) withheld++; else extra_rdy++;
                end
            end else begin
                din_valid = 1'($urandom_range(0, 1)); din_data = 8'($urandom);
            end
            acc_prev = acc; prev_en = o_en;
            @(negedge clk);
        end
        start = 1'b0; din_valid = 1'b0;
        tests_run++;
        if (!finished) begin
            tests_failed++; $display("FAIL session_timeout: done seen=%0d expected 1 within budget", ndone);
        end
        tests_run++;
        if (nshift !== len) begin
            tests_failed++; $display("FAIL shift_count: got %0d expected %0d", nshift, len);
        end
        bad = 0;
        for (int i = 0; i < len; i++) if (got_bit[i] !== exp_bit[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL head_sequence: %0d bits differ, expected 0", bad);
        end
        tests_run++;
        if (ndone !== 1) begin
            tests_failed++; $display("FAIL done_count: got %0d expected 1", ndone);
        end
        tests_run++;
        if (o_cnt !== 5'(len)) begin
            tests_failed++; $display("FAIL final_count: got %0d expected %0d", o_cnt, len);
        end
        tests_run++;
        if (wi !== nw || extra_rdy !== 0) begin
            tests_failed++; $display("FAIL words_taken: got %0d words, %0d extra ready, expected %0d, 0", wi, extra_rdy, nw);
        end
        bad = 0;
        for (int i = 0; i < len; i++) if (chain[len - 1 - i] !== exp_bit[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL chain_contents: %0d flops differ, expected 0 (chain=%h)", bad, chain);
        end
`ifdef CCFF_LOADER_READBACK_EN
        tests_run++;
        if (nrb !== nexp_rb) begin
            tests_failed++; $display("FAIL rb_count: got %0d expected %0d", nrb, nexp_rb);
        end
        bad = 0;
        for (int k = 0; k < nexp_rb && k < nrb; k++) if (got_rb[k] !== exp_rb[k]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++; $display("FAIL rb_words: got %h,%h expected %h,%h", got_rb[0], got_rb[1], exp_rb[0], exp_rb[1]);
        end
`else
        tests_run++;
        if (rb_bad !== 1'b0) begin
            tests_failed++; $display("FAIL rb_disabled: readback activity seen=%b expected 0", rb_bad);
        end
`endif
    endtask

    task automatic check_all_zero(input string name);
        tests_run++;
        if ({o_rdy, o_head, o_en, o_busy, o_done, o_rb_valid} !== 6'b0 || o_cnt !== 5'd0 || o_rb_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL %s: rdy,head,en,busy,done,rbv=%b cnt=%0d rb=%h expected all 0",
                     name, {o_rdy, o_head, o_en, o_busy, o_done, o_rb_valid}, o_cnt, o_rb_data);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sel = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state16");
        sel = 1;
        check_all_zero("reset_state12");
        rst = 1'b0; sel = 0;
        @(negedge clk);
        check_all_zero("post_reset_idle");
    endtask

    task automatic test_back_to_back;
        sel = 0; nw = 2; wq[0] = 8'hA5; wq[1] = 8'hC3; gap[0] = 0; gap[1] = 0;
        run_session(-1);
        tests_run++;
        if (gap_max !== 0) begin
            tests_failed++; $display("FAIL back_to_back_contiguous: enable gap %0d expected 0", gap_max);
        end
    endtask

    task automatic test_gap;
        sel = 0; nw = 2; wq[0] = 8'hA5; wq[1] = 8'hC3; gap[0] = 0; gap[1] = 3;
        run_session(-1);
        tests_run++;
        if (gap_max < 3) begin
            tests_failed++; $display("FAIL gap_enable_low: got %0d low cycles expected >=3", gap_max);
        end
    endtask

    task automatic test_partial_word;
        sel = 1; nw = 2; wq[0] = 8'hFF; wq[1] = 8'hF0; gap[0] = 1; gap[1] = 0;
        run_session(-1);
        sel = 0;
    endtask

    task automatic test_reset_mid;
        int nshift;
        sel = 0; nshift = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 50 && nshift < 5; cyc++) begin
            if (o_en) nshift++;
            din_valid = o_rdy; din_data = 8'h3C;
            if (nshift < 5) @(negedge clk);
        end
        tests_run++;
        if (nshift !== 5) begin
            tests_failed++; $display("FAIL reset_mid_reach: got %0d shifts expected 5", nshift);
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_async");
        @(negedge clk);
        rst = 1'b0; din_valid = 1'b0;
        nw = 2; wq[0] = 8'($urandom); wq[1] = 8'($urandom); gap[0] = 0; gap[1] = 0;
        run_session(-1);
    endtask

    task automatic test_start_during_shift;
        sel = 0; nw = 2; wq[0] = 8'h69; wq[1] = 8'h1E; gap[0] = 0; gap[1] = 1;
        run_session(10);
    endtask

    task automatic test_readback;
        sel = 0; nw = 2; gap[0] = 0; gap[1] = 0;
        wq[0] = 8'h5A; wq[1] = 8'h96;
        run_session(-1);
        wq[0] = 8'h00; wq[1] = 8'h00;
        run_session(-1);
`ifdef CCFF_LOADER_READBACK_EN
        tests_run++;
        if (got_rb[0] !== 8'h5A || got_rb[1] !== 8'h96) begin
            tests_failed++; $display("FAIL readback_words: got %h,%h expected 5a,96", got_rb[0], got_rb[1]);
        end
`endif
    endtask

    task automatic test_random;
        for (int s = 0; s < 6; s++) begin
            sel = int'($urandom_range(0, 1)); nw = 2;
            wq[0] = 8'($urandom); wq[1] = 8'($urandom);
            gap[0] = int'($urandom_range(0, 2)); gap[1] = int'($urandom_range(0, 4));
            run_session(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 11)) : -1);
        end
        sel = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_partial_word();
        test_reset_mid();
        test_start_during_shift();
        test_readback();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Serializes configuration bitstream words from the host-side programming interface onto the configuration flip-flop chain (`ccff_head`) that threads through every routing-mux and LUT memory of the fabric. The block sits directly upstream of the first chain memory. It owns the shift sequencing, and it drives a shift enable that gates `prog_clk` into the chain. An optional readback path captures the bits leaving the chain at `ccff_tail`.

## Interface
Parameters:
- `DATA_W`, default 8: bitstream word width accepted per handshake.
- `CHAIN_LEN`, default 1024: total flops in the chain, ≥1. Counter width `CNT_W = $clog2(CHAIN_LEN+1)` is derived, not set.

Ports:
- `prog_clk`  in  1  programming clock; all state on rising edge.
- `prog_reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a programming session.
- `din_valid`  in  1  bitstream word valid.
- `din_data`  in  DATA_W  bitstream word; MSB is shifted first.
- `din_ready`  out  1  loader accepts `din_data` this cycle.
- `ccff_head`  out  1  serial bit into chain.
- `ccff_shift_en`  out  1  chain clock-gate enable; chain shifts on the `prog_clk` edge ending a cycle with enable high.
- `ccff_tail`  in  1  serial bit out of the last chain flop.
- `busy`  out  1  session in progress.
- `done`  out  1  one-cycle pulse when the session completes.
- `bit_count`  out  CNT_W  bits shifted in the current or last session.
- `rb_data`  out  DATA_W  readback word.
- `rb_valid`  out  1  one-cycle pulse, `rb_data` valid.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - `busy`=0 and `din_ready`=0.
  - `start` clears `bit_count` and moves to LOAD.
- LOAD:
  - `din_ready`=1 and `ccff_shift_en`=0.
  - On `din_valid & din_ready`, the word goes into the shift register, the in-word index is set to 0, and the FSM moves to SHIFT.
- SHIFT:
  - `ccff_shift_en`=1 and `ccff_head` = shift-register MSB.
  - Each cycle: shift left by 1, increment `bit_count`, increment the in-word index.
  - Completion: when `bit_count` reaches CHAIN_LEN-1 in this cycle (last bit), go to DONE.
  - Word boundary: otherwise, when index = DATA_W-1, `din_ready`=1 in this same cycle.
    - If a word is accepted, it is loaded and SHIFT continues with no bubble.
    - If no word is accepted, go to LOAD.
- DONE:
  - `done`=1 for exactly one cycle, then IDLE.
  - `busy` is 1 in LOAD, SHIFT and DONE.
- Exactly CHAIN_LEN shift cycles per session.
  - When CHAIN_LEN mod DATA_W ≠ 0, only the upper CHAIN_LEN mod DATA_W bits of the final word are shifted; its low bits are discarded.
  - The first bit shifted lands in the flop nearest `ccff_tail`.
- `start` while `busy` is ignored.
- `din_valid` while `din_ready`=0 is ignored; no word is consumed.
- `ccff_head` holds its last value while `ccff_shift_en`=0.
- `bit_count` holds after DONE until the next `start`.

## Timing
- Reset values:
  - state=IDLE.
  - `din_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `rb_valid` = 0.
  - `bit_count`=0, `rb_data`=0, shift register = 0.
- Outputs `ccff_head`, `ccff_shift_en`, `done`, `busy`, `rb_*` are registered. `din_ready` is decoded from state and index.
- Latency and cadence:
  - `start` at edge k: LOAD during cycle k+1.
  - Word accepted at edge j: first bit on `ccff_head` with enable high during cycle j+1.
  - Back-to-back words yield continuous `ccff_shift_en`.
- Last shift in cycle n; `done` high in cycle n+1; `busy` low from cycle n+2.
- `prog_reset` mid-session asynchronously forces all reset values.
  - Chain contents are then partial and undefined.
  - The host must issue a new `start`.

## Configuration
- `CCFF_LOADER_READBACK_EN`, defined:
  - In every SHIFT cycle, `ccff_tail` is sampled on the same edge the chain shifts, into a DATA_W readback register, MSB first.
  - After each DATA_W samples, `rb_data` is updated and `rb_valid` pulses for one cycle.
  - A final partial word is emitted left-justified with zero fill, coincident with `done`.
- `CCFF_LOADER_READBACK_EN`, undefined:
  - `rb_data`=0 and `rb_valid`=0 constantly; `ccff_tail` is unused.
  - Ports remain present in both builds.

## Test plan
- DATA_W=8, CHAIN_LEN=16, words 0xA5 then 0xC3 offered back-to-back -> 16 contiguous `ccff_shift_en` cycles.
  - `ccff_head` sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
  - `done` the cycle after the last shift; a 16-flop chain model holds the bits in that order from tail to head.
- Same config, `din_valid` low 3 cycles between words -> `ccff_shift_en` low ≥3 cycles, `ccff_head` stable, `bit_count` frozen at 8, total shifts still 16.
- CHAIN_LEN=12, words 0xFF, 0xF0 -> exactly 12 shifts, all ones on `ccff_head`, `bit_count`=12, no third `din_ready`.
- `prog_reset` pulsed at shift bit 5 -> all outputs at reset values immediately. A `start` pulse then runs a full 16-bit session correctly.
- `start` pulsed during SHIFT -> ignored, `bit_count` not cleared, a single `done` results.
- Readback build: chain model preloaded with 0x5A,0x96 from a prior session, reload with 0x00,0x00 -> `rb_valid` twice, `rb_data` 0x5A then 0x96.
